// File: rtl/adsr_if.sv
// Control and level bundle between the MIDI front end and the ADSR envelope.
// The master drives note/rate settings; the envelope (slave) drives the levels back.
interface adsr_if;
    logic        gate_in;
    logic        trig_in;
    logic [6:0]  vel_in;
    logic [7:0]  attack_in;
    logic [7:0]  decay_in;
    logic [7:0]  release_in;
    logic [7:0]  sustain_in;
    logic [15:0] env_out;
    logic [7:0]  vol_out;
    logic [2:0]  stage_out;
    logic        active_out;

    modport master (
        output gate_in, trig_in, vel_in, attack_in, decay_in, release_in, sustain_in,
        input  env_out, vol_out, stage_out, active_out
    );

    modport slave (
        input  gate_in, trig_in, vel_in, attack_in, decay_in, release_in, sustain_in,
        output env_out, vol_out, stage_out, active_out
    );
endinterface

// File: rtl/adsr_envelope.sv
// Linear ADSR amplitude envelope stepped on a prescaled tick, with a
// registered velocity-scaled volume output for the synthesizer.
module adsr_envelope #(
    parameter int RATE_DIV = 2048
) (
    input logic   clk_in,
    input logic   rst_in,
    adsr_if.slave bus
);
    localparam int CNT_W = (RATE_DIV > 2) ? $clog2(RATE_DIV) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } stage_e;

    stage_e           stage_q, stage_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      env_q, env_d;
    logic [6:0]       vel_q, vel_d;
    logic [7:0]       vol_q, vol_d;

    logic        tick;
    logic        honoured;
    logic [15:0] step_a, step_d, step_r, sus_lvl;
    logic [14:0] prod;
    logic [16:0] upd;

    // Each helper returns {stage_done, next_level}.
    function automatic logic [16:0] attack_next(input logic [15:0] lvl, input logic [15:0] step);
        logic [16:0] sum;
        sum = {1'b0, lvl} + {1'b0, step};
        if (sum >= 17'h0FFFF) return {1'b1, 16'hFFFF};
        return {1'b0, sum[15:0]};
    endfunction

    // A live sustain change can leave the level below target; that also ends decay.
    function automatic logic [16:0] decay_next(input logic [15:0] lvl, input logic [15:0] step,
                                               input logic [15:0] tgt);
        if ((lvl <= tgt) || ((lvl - tgt) <= step)) return {1'b1, tgt};
        return {1'b0, lvl - step};
    endfunction

    function automatic logic [16:0] release_next(input logic [15:0] lvl, input logic [15:0] step);
        if (lvl <= step) return {1'b1, 16'h0000};
        return {1'b0, lvl - step};
    endfunction

    assign tick     = (cnt_q == CNT_W'(RATE_DIV - 1));
    assign honoured = bus.trig_in & bus.gate_in;
    assign step_a   = {3'b000, 9'd256 - {1'b0, bus.attack_in}, 4'b0000};
    assign step_d   = {3'b000, 9'd256 - {1'b0, bus.decay_in}, 4'b0000};
    assign step_r   = {3'b000, 9'd256 - {1'b0, bus.release_in}, 4'b0000};
    assign sus_lvl  = {bus.sustain_in, bus.sustain_in};
    assign prod     = {7'd0, env_q[15:8]} * {8'd0, vel_q};

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        stage_d = stage_q;
        env_d   = env_q;
        vel_d   = vel_q;
        vol_d   = prod[14:7];
        upd     = '0;

        // Tick arithmetic uses the stage currently held.
        if (tick) begin
            case (stage_q)
                ST_ATTACK: begin
                    upd   = attack_next(env_q, step_a);
                    env_d = upd[15:0];
                    if (upd[16]) stage_d = ST_DECAY;
                end
                ST_DECAY: begin
                    upd   = decay_next(env_q, step_d, sus_lvl);
                    env_d = upd[15:0];
                    if (upd[16]) stage_d = ST_SUSTAIN;
                end
                ST_SUSTAIN: env_d = sus_lvl;
                ST_RELEASE: begin
                    upd   = release_next(env_q, step_r);
                    env_d = upd[15:0];
                    if (upd[16]) stage_d = ST_IDLE;
                end
                default: env_d = '0;
            endcase
        end

        // Note events override any tick-driven stage change.
        if (honoured) begin
            stage_d = ST_ATTACK;
            vel_d   = bus.vel_in;
        end else if (!bus.gate_in &&
                     (stage_q == ST_ATTACK || stage_q == ST_DECAY || stage_q == ST_SUSTAIN)) begin
            stage_d = ST_RELEASE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cnt_q   <= '0;
            stage_q <= ST_IDLE;
            env_q   <= '0;
            vel_q   <= '0;
            vol_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            env_q   <= env_d;
            vel_q   <= vel_d;
            vol_q   <= vol_d;
        end
    end

    assign bus.env_out    = env_q;
    assign bus.vol_out    = vol_q;
    assign bus.stage_out  = stage_q;
    assign bus.active_out = (stage_q != ST_IDLE);
endmodule

// File: tb/tb_adsr_envelope.sv
// Directed scoreboard bench for adsr_envelope at RATE_DIV=4: stimulus queues
// hand-computed expectations, a negedge monitor pops and compares them.
module tb_adsr_envelope;
    localparam int SEL_ENV = 0, SEL_VOL = 1, SEL_STAGE = 2, SEL_ACT = 3;

    typedef struct {
        int          sel;
        logic [15:0] exp;
        string       name;
    } item_t;

    logic  clk_in = 1'b0;
    logic  rst_in;
    adsr_if bus ();

    adsr_envelope #(.RATE_DIV(4)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    item_t       sb[$];
    int          checks = 0;
    int          errors = 0;
    int          e = 0;
    item_t       mon_it;
    logic [15:0] act;

    // Monitor: every expectation queued since the last negedge is compared here.
    always @(negedge clk_in) begin
        while (sb.size() > 0) begin
            mon_it = sb.pop_front();
            case (mon_it.sel)
                SEL_ENV:   act = bus.env_out;
                SEL_VOL:   act = {8'd0, bus.vol_out};
                SEL_STAGE: act = {13'd0, bus.stage_out};
                default:   act = {15'd0, bus.active_out};
            endcase
            checks++;
            if (act !== mon_it.exp) begin
                errors++;
                $display("FAIL %s at edge %0d: got %0d expected %0d", mon_it.name, e, act, mon_it.exp);
            end
        end
    end

    task automatic chk(input int sel, input logic [15:0] v, input string nm);
        item_t it;
        it.sel  = sel;
        it.exp  = v;
        it.name = nm;
        sb.push_back(it);
    endtask

    task automatic adv();
        @(posedge clk_in);
        #2;
        e++;
    endtask

    task automatic goto(input int n);
        while (e < n) adv();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_in         = 1'b0;
        bus.gate_in    = 1'b0;
        bus.trig_in    = 1'b0;
        bus.vel_in     = 7'd0;
        bus.attack_in  = 8'd0;
        bus.decay_in   = 8'd0;
        bus.release_in = 8'd0;
        bus.sustain_in = 8'h80;
        adv();
        adv();
        chk(SEL_ENV, 16'd0, "reset_env");
        chk(SEL_VOL, 16'd0, "reset_vol");
        chk(SEL_STAGE, 16'd0, "reset_stage");
        chk(SEL_ACT, 16'd0, "reset_active");

        // Basic ADSR: trigger sampled at E1, ticks at E4k.
        rst_in      = 1'b1;
        e           = 0;
        bus.gate_in = 1'b1;
        bus.trig_in = 1'b1;
        bus.vel_in  = 7'd127;
        adv();
        bus.trig_in = 1'b0;
        chk(SEL_STAGE, 16'd1, "attack_stage");
        chk(SEL_ACT, 16'd1, "attack_active");
        chk(SEL_ENV, 16'd0, "attack_env_start");
        goto(60);
        chk(SEL_ENV, 16'd61440, "attack_tick15");
        chk(SEL_STAGE, 16'd1, "attack_tick15_stage");
        goto(61);
        chk(SEL_VOL, 16'd238, "attack_vol");
        goto(64);
        chk(SEL_ENV, 16'hFFFF, "attack_sat");
        chk(SEL_STAGE, 16'd2, "decay_stage");
        goto(65);
        chk(SEL_VOL, 16'd253, "vol_max");
        goto(92);
        chk(SEL_ENV, 16'd36863, "decay_tick7");
        chk(SEL_STAGE, 16'd2, "decay_tick7_stage");
        goto(96);
        chk(SEL_ENV, 16'h8080, "sustain_env");
        chk(SEL_STAGE, 16'd3, "sustain_stage");
        goto(97);
        chk(SEL_VOL, 16'd127, "sustain_vol");

        // Release from 0x8080 with step 4096.
        bus.gate_in = 1'b0;
        goto(98);
        chk(SEL_STAGE, 16'd4, "release_stage");
        chk(SEL_ENV, 16'h8080, "release_env_hold");
        goto(128);
        chk(SEL_ENV, 16'd128, "release_tick8");
        goto(132);
        chk(SEL_ENV, 16'd0, "release_end_env");
        chk(SEL_STAGE, 16'd0, "release_end_idle");
        chk(SEL_ACT, 16'd0, "release_end_active");
        goto(133);
        chk(SEL_VOL, 16'd0, "release_end_vol");

        // Trigger without gate is ignored.
        bus.trig_in = 1'b1;
        adv();
        bus.trig_in = 1'b0;
        chk(SEL_STAGE, 16'd0, "ignored_trig_stage");
        chk(SEL_ENV, 16'd0, "ignored_trig_env");
        goto(136);
        chk(SEL_ENV, 16'd0, "idle_tick_env");
        chk(SEL_STAGE, 16'd0, "idle_tick_stage");

        // Second note up to sustain at E232.
        bus.gate_in = 1'b1;
        bus.trig_in = 1'b1;
        adv();
        bus.trig_in = 1'b0;
        goto(232);
        chk(SEL_ENV, 16'h8080, "note2_sustain_env");
        chk(SEL_STAGE, 16'd3, "note2_sustain_stage");
        bus.sustain_in = 8'h20;
        goto(236);
        chk(SEL_ENV, 16'h2020, "sustain_track_env");
        chk(SEL_STAGE, 16'd3, "sustain_track_stage");
        goto(237);
        chk(SEL_VOL, 16'd31, "sustain_track_vol");
        bus.sustain_in = 8'h80;
        goto(240);
        chk(SEL_ENV, 16'h8080, "sustain_restore_env");

        // Release step 2752 reaches 0x4000 after 6 ticks, then retrigger.
        bus.gate_in    = 1'b0;
        bus.release_in = 8'd84;
        goto(241);
        chk(SEL_STAGE, 16'd4, "rel2_stage");
        goto(264);
        chk(SEL_ENV, 16'h4000, "rel2_env_4000");
        chk(SEL_STAGE, 16'd4, "rel2_stage_before_retrig");
        bus.gate_in = 1'b1;
        bus.trig_in = 1'b1;
        bus.vel_in  = 7'd64;
        adv();
        bus.trig_in = 1'b0;
        chk(SEL_STAGE, 16'd1, "retrig_stage");
        chk(SEL_ENV, 16'h4000, "retrig_env_kept");
        chk(SEL_ACT, 16'd1, "retrig_active");
        goto(266);
        chk(SEL_VOL, 16'd32, "retrig_vol_vel64");
        goto(268);
        chk(SEL_ENV, 16'h5000, "retrig_attack_up");
        chk(SEL_STAGE, 16'd1, "retrig_attack_stage");
        goto(269);
        chk(SEL_VOL, 16'd40, "retrig_vol2");

        // Sustain 0xFF: decay ends on its first tick.
        bus.sustain_in = 8'hFF;
        goto(312);
        chk(SEL_ENV, 16'hFFFF, "s255_attack_sat");
        chk(SEL_STAGE, 16'd2, "s255_decay");
        goto(315);
        chk(SEL_STAGE, 16'd2, "s255_decay_hold");
        goto(316);
        chk(SEL_STAGE, 16'd3, "s255_sustain");
        chk(SEL_ENV, 16'hFFFF, "s255_sustain_env");

        // Reset mid-note, then reset mid-attack at 0x3000.
        rst_in = 1'b0;
        goto(317);
        chk(SEL_ENV, 16'd0, "rst_note_env");
        chk(SEL_VOL, 16'd0, "rst_note_vol");
        chk(SEL_STAGE, 16'd0, "rst_note_stage");
        chk(SEL_ACT, 16'd0, "rst_note_active");
        rst_in         = 1'b1;
        bus.trig_in    = 1'b1;
        bus.vel_in     = 7'd127;
        bus.sustain_in = 8'h80;
        adv();
        bus.trig_in = 1'b0;
        chk(SEL_STAGE, 16'd1, "rst2_attack_stage");
        goto(329);
        chk(SEL_ENV, 16'h3000, "rst2_env_3000");
        chk(SEL_STAGE, 16'd1, "rst2_attack_stage_before");
        rst_in = 1'b0;
        goto(330);
        chk(SEL_ENV, 16'd0, "rst2_env");
        chk(SEL_VOL, 16'd0, "rst2_vol");
        chk(SEL_STAGE, 16'd0, "rst2_stage");
        rst_in = 1'b1;
        goto(338);
        chk(SEL_STAGE, 16'd0, "rst2_stays_idle");
        chk(SEL_ENV, 16'd0, "rst2_env_stays0");
        chk(SEL_ACT, 16'd0, "rst2_active_stays0");
        adv();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adsr_envelope.md
# adsr_envelope

Per-note ADSR amplitude envelope generator between the MIDI front end and the synthesizer's `vol_in`. It consumes a note gate, a single-cycle note-on trigger and a 7-bit velocity, and runs a linear attack/decay/sustain/release state machine on a prescaled tick. It emits an 8-bit, velocity-scaled volume so synthesizer output fades in and out instead of switching abruptly. It runs in the 98.3 MHz audio domain.

## Interface
- `RATE_DIV`, default 2048: `clk_in` cycles per envelope tick (≈48 kHz at 98.3 MHz); must be ≥2.
- `clk_in` input 1: system clock; every register is clocked on its rising edge.
- `rst_in` input 1: reset, synchronous, active-low; one clock, synchronous active-low reset.
- `gate_in` input 1: 1 while the note is held.
- `trig_in` input 1: single-cycle note-on pulse; honoured only when `gate_in`=1 in the same cycle.
- `vel_in` input 7: note velocity, latched on an honoured trigger.
- `attack_in`, `decay_in`, `release_in` input 8 each: rate settings; larger value means slower.
- `sustain_in` input 8: sustain level.
- `env_out` output 16: raw envelope level, unsigned.
- `vol_out` output 8: velocity-scaled volume for the synthesizer.
- `stage_out` output 3: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- `active_out` output 1: 1 whenever stage ≠ IDLE.

## Operation
- Prescaler: free-running counter 0..RATE_DIV-1. `tick` is asserted for one cycle when the count = RATE_DIV-1, then the count wraps to 0.
- Step sizes are 16-bit and computed combinationally: step_x = (256 − x_in) << 4, range 16..4096. Sustain level S = {sustain_in, sustain_in}.
- Stage transitions are checked every cycle, in priority order:
  - Honoured trigger, from any stage: go to ATTACK and latch `vel_in`. `env` is NOT cleared; attack continues from the current level.
  - `gate_in`=0 in ATTACK, DECAY or SUSTAIN: go to RELEASE.
  - A trigger arriving while `gate_in`=0 is ignored.
- Level update, only on `tick`, using the stage held at that cycle:
  - ATTACK: if env + step_a ≥ 0xFFFF (17-bit compare), env becomes 0xFFFF and stage becomes DECAY. Otherwise env += step_a.
  - DECAY: if env − S ≤ step_d, env becomes S and stage becomes SUSTAIN. Otherwise env −= step_d. If S = 0xFFFF, SUSTAIN is reached on the first decay tick.
  - SUSTAIN: env becomes S on every tick, so live `sustain_in` changes take effect at the next tick.
  - RELEASE: if env ≤ step_r, env becomes 0 and stage becomes IDLE. Otherwise env −= step_r.
  - IDLE: env holds at 0.
- A stage change and a tick in the same cycle: the tick applies the old stage's arithmetic, the stage register takes the new value, and the new stage's arithmetic starts at the next tick.
- Volume: vol_out = (env[15:8] × vel_lat) >> 7, registered. Maximum value is 253.
- Reset (`rst_in`=0 at an edge) state: env 0, vol_out 0, stage IDLE, active_out 0, vel_lat 0, prescaler 0. Reset mid-note aborts immediately with no release phase.

## Timing
- `stage_out` and `active_out` update on the edge that samples the trigger or gate change, so they are visible 1 cycle later.
- `env_out` updates on the edge that samples `tick`.
- `vol_out` lags `env_out` by exactly 1 cycle. It also reflects a new `vel_lat` 1 cycle after the latch.
- First tick after reset release occurs RATE_DIV cycles after the first edge with `rst_in`=1.
- Nothing stalls: the block accepts a trigger in every cycle, and back-to-back triggers each re-latch velocity.

## Test plan
- Bench runs RATE_DIV=4 unless stated.
- Basic ADSR: attack=0, decay=0, sustain=0x80, vel=127, trigger with gate held.
  - Attack: env reaches 61440 at tick 15 and saturates to 0xFFFF at tick 16, then stage=DECAY.
  - Decay: after 8 more ticks env=0x8080 and stage=SUSTAIN; vol_out=127.
- Release: from the 0x8080 sustain, drop gate with release=0.
  - stage=RELEASE 1 cycle later.
  - env=128 after 8 ticks, 0 at tick 9, then stage=IDLE, active_out=0 and vol_out=0 one cycle later.
- Retrigger mid-release: trigger when env=0x4000.
  - stage=ATTACK, and env continues upward from 0x4000 (no drop to 0).
  - The new vel=64 is latched, so vol_out = (env[15:8]×64)>>7.
- Ignored trigger and sustain edge cases:
  - trig_in=1 with gate_in=0 while IDLE: stage stays IDLE, env stays 0.
  - sustain_in=0xFF: DECAY lasts exactly one tick.
- Sustain tracking: change sustain_in from 0x80 to 0x20 while in SUSTAIN; env=0x2020 at the next tick.
- Reset mid-attack: assert rst_in=0 for one cycle with env=0x3000.
  - Next cycle: env=0, vol_out=0, stage=IDLE.
  - With the gate still held and no new trigger, the stage stays IDLE.
